mem_stage: RTL and testbench

Memory-access stage of the MIPS pipeline, directly downstream of the execution stage. It takes the instruction word, the ALU result (effective address or computed value) and the store data from execution. Loads and stores are carried out over a req/ack data-memory port with byte-lane alignment and sign/zero extension. The block stalls upstream while an access is outstanding, then presents a registered write-back value.

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; req/ack data port with byte-lane alignment,
// load sign/zero extension, access timeout and a registered write-back value.
module mem_stage #(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Ins,
   input  logic [31:0] Result,
   input  logic [31:0] Rdata2,
   input  logic        valid,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] Wdata,
   output logic        wb_valid,
   output logic        err
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    op_q, op_d;
   logic [1:0]    off_q, off_d;
   logic          req_q, req_d, we_q, we_d, wbv_q, wbv_d, err_q, err_d;
   logic [31:0]   addr_q, addr_d, wdt_q, wdt_d, wd_q, wd_d;
   logic [3:0]    be_q, be_d;
   logic [5:0]    op;
   logic [1:0]    off;
   logic          is_ld, is_st, mis, tmo, stall_c, unused_ins;
   logic [7:0]    lb;
   logic [15:0]   lh;
   logic [31:0]   ld;
   assign op         = Ins[31:26];
   assign off        = Result[1:0];
   assign unused_ins = ^Ins[25:0];
   assign is_ld      = op inside {LB, LH, LW, LBU, LHU};
   assign is_st      = op inside {SB, SH, SW};
   assign mis        = (op inside {LH, LHU, SH} && off[0]) || (op inside {LW, SW} && off != 2'b00);
   assign tmo        = !dmem_ack && cnt_q == CW'(TIMEOUT_CYC - 1);
   assign lb         = dmem_rdata[{off_q, 3'b000} +: 8];
   assign lh         = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   assign ld         = op_q == LB  ? {{24{lb[7]}}, lb} :
                       op_q == LBU ? {24'h0, lb} :
                       op_q == LH  ? {{16{lh[15]}}, lh} :
                       op_q == LHU ? {16'h0, lh} :
                       op_q == LW  ? dmem_rdata : 32'h0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      off_d   = off_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdt_d   = wdt_q;
      wd_d    = wd_q;
      wbv_d   = 1'b0;
      err_d   = 1'b0;
      stall_c = 1'b0;
      if (state_q == IDLE) begin
         if (valid && !(is_ld || is_st)) begin
            wd_d  = Result;
            wbv_d = 1'b1;
         end else if (valid && mis) begin
            err_d = 1'b1;
         end else if (valid) begin
            stall_c = 1'b1;
            op_d    = op;
            off_d   = off;
            req_d   = 1'b1;
            we_d    = is_st;
            addr_d  = {Result[31:2], 2'b00};
            be_d    = op == SB ? 4'b0001 << off : op == SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdt_d   = op == SB ? {4{Rdata2[7:0]}} : op == SH ? {2{Rdata2[15:0]}} : op == SW ? Rdata2 : 32'h0;
            cnt_d   = '0;
            state_d = WAIT;
         end
      end else if (dmem_ack) begin
         req_d   = 1'b0;
         wbv_d   = 1'b1;
         wd_d    = ld;
         state_d = IDLE;
      end else if (tmo) begin
         // final WAIT cycle releases upstream; the instruction retires as an error
         req_d   = 1'b0;
         err_d   = 1'b1;
         wd_d    = 32'h0;
         state_d = IDLE;
      end else begin
         cnt_d   = cnt_q + 1'b1;
         stall_c = 1'b1;
      end
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         off_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdt_q   <= '0;
         wd_q    <= '0;
         wbv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdt_q   <= wdt_d;
         wd_q    <= wd_d;
         wbv_q   <= wbv_d;
         err_q   <= err_d;
      end
   end
   // stall is combinational, so reset must mask it directly
   assign stall      = RST & stall_c;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdt_q;
   assign Wdata      = wd_q;
   assign wb_valid   = wbv_q;
   assign err        = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, randomized ops against a behavioural model,
// and hand sequences for timeout, reset mid-access and stray acks.
module tb_mem_stage;
   logic        CLK = 1'b0, RST = 1'b0, valid = 1'b0, dmem_ack = 1'b0;
   logic [31:0] Ins = '0, Result = '0, Rdata2 = '0, dmem_rdata = '0;
   logic        stall, dmem_req, dmem_we, wb_valid, err;
   logic [31:0] dmem_addr, dmem_wdata, Wdata;
   logic [3:0]  dmem_be;
   int          n_pass = 0, n_tot = 0;

   mem_stage #(.TIMEOUT_CYC(4)) dut (
      .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2), .valid(valid),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .Wdata(Wdata), .wb_valid(wb_valid), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int sz(input logic [5:0] op);
      case (op)
         6'h20, 6'h24, 6'h28: return 1;
         6'h21, 6'h25, 6'h29: return 2;
         6'h23, 6'h2B:        return 4;
         default:             return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input int off, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * off)) & 32'hFF;
      h = (rd >> (8 * off)) & 32'hFFFF;
      case (op)
         6'h20:   return b >= 128 ? b - 256 : b;
         6'h24:   return b;
         6'h21:   return h >= 32768 ? h - 65536 : h;
         6'h25:   return h;
         6'h23:   return rd;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [5:0] op, input int off);
      if (op < 6'h28 || sz(op) == 4) return 4'hF;
      return sz(op) == 1 ? 4'b0001 << off : 4'b0011 << off;
   endfunction

   function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] rd2);
      case (op)
         6'h28:   return (rd2 & 32'hFF) * 32'h0101_0101;
         6'h29:   return (rd2 & 32'hFFFF) * 32'h0001_0001;
         6'h2B:   return rd2;
         default: return 0;
      endcase
   endfunction

   task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [31:0] rdata, input int lat, input logic [31:0] ew,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic eerr);
      bit mem;
      mem = sz(op) != 0;
      @(posedge CLK); #1;
      Ins = {op, 26'($urandom)}; Result = addr; Rdata2 = rd2; valid = 1'b1; dmem_ack = 1'b0;
      @(negedge CLK);
      check("wb_valid_one_cycle", wb_valid, 0);
      check("err_one_cycle", err, 0);
      if (!mem || eerr) begin
         check("stall_single_cycle", stall, 0);
         @(posedge CLK); #1;
         valid = 1'b0;
         @(negedge CLK);
         check("wb_valid_single", wb_valid, !mem);
         check("err_single", err, eerr);
         check("req_single", dmem_req, 0);
         if (!mem) check("wdata_alu", Wdata, ew);
      end else begin
         check("stall_launch", stall, 1);
         check("req_launch", dmem_req, 0);
         for (int k = 1; k <= lat; k++) begin
            @(posedge CLK); #1;
            dmem_ack = (k == lat);
            dmem_rdata = (k == lat) ? rdata : $urandom;
            @(negedge CLK);
            check("stall_wait", stall, k != lat);
            check("req_wait", dmem_req, 1);
            if (k == 1) begin
               check("addr", dmem_addr, addr & ~32'h3);
               check("we", dmem_we, op >= 6'h28);
               check("be", dmem_be, ebe);
               check("wdata_out", dmem_wdata, ewd);
            end
         end
         @(posedge CLK); #1;
         dmem_ack = 1'b0; valid = 1'b0;
         @(negedge CLK);
         check("wb_valid_mem", wb_valid, 1);
         check("err_mem", err, 0);
         check("wdata_mem", Wdata, ew);
         check("req_drop", dmem_req, 0);
      end
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr, rd2, rdata;
      int          lat;
      logic [31:0] ew;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic        eerr;
   } vec_t;

   vec_t        tbl[11];
   logic [5:0]  ops[13] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                           6'h00, 6'h09, 6'h0F, 6'h22, 6'h2A};

   initial begin
      tbl[0]  = '{6'h00, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h1234_5678, 4'h0, 32'h0, 1'b0};
      tbl[1]  = '{6'h20, 32'h0000_0100, 32'h0, 32'hFFFF_FF80, 3, 32'hFFFF_FF80, 4'hF, 32'h0, 1'b0};
      tbl[2]  = '{6'h24, 32'h0000_0100, 32'h0, 32'hFFFF_FF80, 3, 32'h0000_0080, 4'hF, 32'h0, 1'b0};
      tbl[3]  = '{6'h28, 32'h0000_0203, 32'hAB, 32'h0, 1, 32'h0, 4'b1000, 32'hABAB_ABAB, 1'b0};
      tbl[4]  = '{6'h29, 32'h0000_0202, 32'hAB, 32'h0, 2, 32'h0, 4'b1100, 32'h00AB_00AB, 1'b0};
      tbl[5]  = '{6'h23, 32'h0000_0106, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[6]  = '{6'h21, 32'h0000_0101, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[7]  = '{6'h2B, 32'h0000_0102, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[8]  = '{6'h21, 32'h0000_0102, 32'h0, 32'h8001_1234, 4, 32'hFFFF_8001, 4'hF, 32'h0, 1'b0};
      tbl[9]  = '{6'h23, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      tbl[10] = '{6'h2A, 32'h0000_0055, 32'h0, 32'h0, 0, 32'h0000_0055, 4'h0, 32'h0, 1'b0};
      Ins = {6'h23, 26'h0}; valid = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_stall", stall, 0);
      check("rst_req", dmem_req, 0);
      check("rst_we", dmem_we, 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_be", dmem_be, 0);
      check("rst_wdata_out", dmem_wdata, 0);
      check("rst_wdata", Wdata, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_err", err, 0);
      valid = 1'b0;
      RST = 1'b1;
      foreach (tbl[i])
         run_op(tbl[i].op, tbl[i].addr, tbl[i].rd2, tbl[i].rdata, tbl[i].lat,
                tbl[i].ew, tbl[i].ebe, tbl[i].ewd, tbl[i].eerr);
      for (int i = 0; i < 60; i++) begin
         logic [5:0]  op;
         logic [31:0] a, rd2, rd, ew;
         int          s;
         logic        e;
         op  = ops[$urandom_range(0, 12)];
         s   = sz(op);
         a   = $urandom;
         rd2 = $urandom;
         rd  = $urandom;
         if (s != 0 && $urandom_range(0, 1) == 1) a = a - (a % s);
         e   = s != 0 && (a % s) != 0;
         ew  = s == 0 ? a : m_load(op, a % 4, rd);
         run_op(op, a, rd2, rd, $urandom_range(1, 4), ew, m_be(op, a % 4), m_wd(op, rd2), e);
      end
      run_op(6'h00, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 32'hCAFE_F00D, 4'h0, 32'h0, 1'b0);
      @(posedge CLK); #1;
      Ins = {6'h23, 26'h0}; Result = 32'h10; valid = 1'b1;
      @(negedge CLK);
      check("to_stall_launch", stall, 1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge CLK); #1;
         @(negedge CLK);
         check("to_req", dmem_req, 1);
         check("to_stall", stall, k < 4);
      end
      @(posedge CLK); #1;
      valid = 1'b0;
      @(negedge CLK);
      check("to_req_drop", dmem_req, 0);
      check("to_err", err, 1);
      check("to_wb_valid", wb_valid, 0);
      check("to_wdata", Wdata, 0);
      check("to_stall_after", stall, 0);
      @(posedge CLK); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
      @(negedge CLK);
      check("to_err_one_cycle", err, 0);
      @(posedge CLK); #1;
      dmem_ack = 1'b0;
      @(negedge CLK);
      check("late_ack_wb_valid", wb_valid, 0);
      check("late_ack_req", dmem_req, 0);
      check("late_ack_wdata", Wdata, 0);
      run_op(6'h00, 32'h0000_0077, 32'h0, 32'h0, 0, 32'h0000_0077, 4'h0, 32'h0, 1'b0);
      @(posedge CLK); #1;
      Ins = {6'h23, 26'h0}; Result = 32'h20; valid = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("mid_req", dmem_req, 1);
      #1 RST = 1'b0;
      #1;
      check("mid_rst_req", dmem_req, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_wdata", Wdata, 0);
      check("mid_rst_be", dmem_be, 0);
      check("mid_rst_addr", dmem_addr, 0);
      valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      run_op(6'h25, 32'h0000_0002, 32'h0, 32'h8001_0000, 2, 32'h0000_8001, 4'hF, 32'h0, 1'b0);
      @(posedge CLK); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      dmem_ack = 1'b0;
      @(negedge CLK);
      check("idle_ack_wb_valid", wb_valid, 0);
      check("idle_ack_req", dmem_req, 0);
      check("idle_ack_wdata", Wdata, 32'h0000_8001);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
